// File: rtl/pcie_dllp_tx_scheduler.sv
// VC0 DLLP transmit scheduler: runs InitFC1/InitFC2 flow-control initialisation, then
// arbitrates Ack/Nak and UpdateFC DLLP bodies onto a single registered output stream.
module pcie_dllp_tx_scheduler #(
    parameter logic [7:0]  P_HDR_CR         = 8'h01,
    parameter logic [11:0] P_DATA_CR        = 12'h040,
    parameter logic [7:0]  NP_HDR_CR        = 8'h01,
    parameter logic [11:0] NP_DATA_CR       = 12'h010,
    parameter logic [7:0]  CPL_HDR_CR       = 8'h01,
    parameter logic [11:0] CPL_DATA_CR      = 12'h040,
    parameter int unsigned UPDATE_FC_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        link_up_i,
    input  logic [2:0]  rx_initfc_i,
    input  logic        rx_fc2_seen_i,
    input  logic        acknak_req_i,
    input  logic        acknak_nak_i,
    input  logic [11:0] acknak_seq_i,
    output logic        acknak_ack_o,
    input  logic [2:0]  update_fc_req_i,
    input  logic [23:0] fc_hdr_i,
    input  logic [35:0] fc_data_i,
    output logic [31:0] m_dllp_data_o,
    output logic        m_dllp_valid_o,
    input  logic        m_dllp_ready_i,
    output logic [1:0]  dl_status_o,
    output logic [3:0]  fc_state_o
);

    typedef enum logic [3:0] {
        INIT_FCDLE       = 4'd0,
        INIT_FC1_P       = 4'd1,
        INIT_FC1_NP      = 4'd2,
        INIT_FC1_CPL     = 4'd3,
        CHECK_FC1_VALS   = 4'd4,
        INIT_FC2_P       = 4'd5,
        INIT_FC2_NP      = 4'd6,
        INIT_FC2_CPL     = 4'd7,
        CHECK_FC2_VALS   = 4'd8,
        INIT_FC_COMPLETE = 4'd9
    } flow_control_state_e;

    typedef enum logic [1:0] {
        DL_DOWN   = 2'b00,
        DL_UP     = 2'b01,
        DL_ACTIVE = 2'b10
    } pcie_dl_status_e;

    localparam int unsigned CntW = (UPDATE_FC_CYCLES > 2) ? $clog2(UPDATE_FC_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(UPDATE_FC_CYCLES - 1);

    flow_control_state_e state_q, state_d;
    pcie_dl_status_e     dl_status;
    logic [2:0]          fc1_flag_q, fc1_flag_d;
    logic                fc2_flag_q, fc2_flag_d;
    logic [2:0]          pend_q, pend_d, pend_set, pend_clr;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic [31:0]         data_q, data_d;
    logic                load_ok, load;
    logic [31:0]         load_data;

    function automatic logic [31:0] fc_dllp(input logic [7:0] typ, input logic [7:0] hdr,
                                            input logic [11:0] dat);
        fc_dllp = {dat[7:0], hdr[1:0], 2'b00, dat[11:8], 2'b00, hdr[7:2], typ};
    endfunction

    // Output register is free when empty or being drained this cycle; nothing loads on link loss.
    assign load_ok = link_up_i && (!valid_q || m_dllp_ready_i);

    always_comb begin
        state_d      = state_q;
        dl_status    = DL_UP;
        fc1_flag_d   = fc1_flag_q | rx_initfc_i;
        fc2_flag_d   = fc2_flag_q | rx_fc2_seen_i;
        pend_set     = update_fc_req_i;
        pend_clr     = 3'b000;
        cnt_d        = '0;
        load         = 1'b0;
        load_data    = '0;
        acknak_ack_o = 1'b0;

        unique case (state_q)
            INIT_FCDLE: begin
                dl_status  = DL_DOWN;
                fc1_flag_d = 3'b000;
                fc2_flag_d = 1'b0;
                state_d    = INIT_FC1_P;
            end
            INIT_FC1_P: begin
                load_data = fc_dllp(8'h40, P_HDR_CR, P_DATA_CR);
                load      = load_ok;
                if (load_ok) state_d = INIT_FC1_NP;
            end
            INIT_FC1_NP: begin
                load_data = fc_dllp(8'h50, NP_HDR_CR, NP_DATA_CR);
                load      = load_ok;
                if (load_ok) state_d = INIT_FC1_CPL;
            end
            INIT_FC1_CPL: begin
                load_data = fc_dllp(8'h60, CPL_HDR_CR, CPL_DATA_CR);
                load      = load_ok;
                if (load_ok) state_d = CHECK_FC1_VALS;
            end
            CHECK_FC1_VALS: begin
                state_d = (fc1_flag_q == 3'b111) ? INIT_FC2_P : INIT_FC1_P;
            end
            INIT_FC2_P: begin
                load_data = fc_dllp(8'hC0, P_HDR_CR, P_DATA_CR);
                load      = load_ok;
                if (load_ok) state_d = INIT_FC2_NP;
            end
            INIT_FC2_NP: begin
                load_data = fc_dllp(8'hD0, NP_HDR_CR, NP_DATA_CR);
                load      = load_ok;
                if (load_ok) state_d = INIT_FC2_CPL;
            end
            INIT_FC2_CPL: begin
                load_data = fc_dllp(8'hE0, CPL_HDR_CR, CPL_DATA_CR);
                load      = load_ok;
                if (load_ok) state_d = CHECK_FC2_VALS;
            end
            CHECK_FC2_VALS: begin
                state_d = fc2_flag_q ? INIT_FC_COMPLETE : INIT_FC2_P;
            end
            INIT_FC_COMPLETE: begin
                dl_status = DL_ACTIVE;
                if (cnt_q == CntLast) begin
                    pend_set = 3'b111;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
                if (load_ok) begin
                    if (acknak_req_i) begin
                        load         = 1'b1;
                        acknak_ack_o = 1'b1;
                        load_data    = {acknak_seq_i[7:0], 4'h0, acknak_seq_i[11:8], 8'h00,
                                        (acknak_nak_i ? 8'h10 : 8'h00)};
                    end else if (pend_q[0]) begin
                        load      = 1'b1;
                        pend_clr  = 3'b001;
                        load_data = fc_dllp(8'h80, fc_hdr_i[7:0], fc_data_i[11:0]);
                    end else if (pend_q[1]) begin
                        load      = 1'b1;
                        pend_clr  = 3'b010;
                        load_data = fc_dllp(8'h90, fc_hdr_i[15:8], fc_data_i[23:12]);
                    end else if (pend_q[2]) begin
                        load      = 1'b1;
                        pend_clr  = 3'b100;
                        load_data = fc_dllp(8'hA0, fc_hdr_i[23:16], fc_data_i[35:24]);
                    end
                end
            end
            default: state_d = INIT_FCDLE;
        endcase

        // Set wins over a same-cycle clear so a fresh request is never lost.
        pend_d = (state_q == INIT_FCDLE) ? 3'b000 : ((pend_q & ~pend_clr) | pend_set);

        if (!link_up_i) begin
            state_d = INIT_FCDLE;
            cnt_d   = '0;
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (!link_up_i) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (m_dllp_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT_FCDLE;
            fc1_flag_q <= 3'b000;
            fc2_flag_q <= 1'b0;
            pend_q     <= 3'b000;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            fc1_flag_q <= fc1_flag_d;
            fc2_flag_q <= fc2_flag_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
        end
    end

    assign m_dllp_valid_o = valid_q;
    assign m_dllp_data_o  = data_q;
    assign dl_status_o    = dl_status;
    assign fc_state_o     = state_q;

endmodule
